// File: rtl/vx_tex_pkg.sv
// rtl/vx_tex_pkg.sv - texture CSR field widths, offsets and state struct (honours TEX_MIPMAP_EN)
package vx_tex_pkg;

  localparam int CSR_ADDR_BITS = 12;
  localparam int UUID_BITS     = 44;

  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_LOGW_BITS   = 4;
  localparam int TEX_LOGH_BITS   = 4;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_MIPOFF_BITS = 20;
  localparam int TEX_MAX_LODS    = 12;

  // Per-stage scalar fields (ADDR..FILTER); MIPOFF entries come after them.
  localparam int TEX_NUM_FIELDS = 7;

`ifdef TEX_MIPMAP_EN
  localparam bit TEX_MIPMAP = 1'b1;
`else
  localparam bit TEX_MIPMAP = 1'b0;
`endif

  localparam logic [CSR_ADDR_BITS-1:0] OFF_STAGE  = 12'd0;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_ADDR   = 12'd1;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_LOGW   = 12'd2;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_LOGH   = 12'd3;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_FORMAT = 12'd4;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_WRAPU  = 12'd5;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_WRAPV  = 12'd6;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_FILTER = 12'd7;
  localparam logic [CSR_ADDR_BITS-1:0] OFF_MIPOFF = 12'd8;

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                     addr;
    logic [TEX_LOGW_BITS-1:0]                     logw;
    logic [TEX_LOGH_BITS-1:0]                     logh;
    logic [TEX_FORMAT_BITS-1:0]                   format;
    logic [TEX_WRAP_BITS-1:0]                     wrapu;
    logic [TEX_WRAP_BITS-1:0]                     wrapv;
    logic                                         filter;
    logic [TEX_MAX_LODS-1:0][TEX_MIPOFF_BITS-1:0] mipoff;
  } tex_state_t;

  // Width of a stage index; a single stage still gets a 1-bit select.
  function automatic int tex_stage_bits(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/vx_tex_csr_file_if.sv
// rtl/vx_tex_csr_file_if.sv - CSR write channel plus texture state lookup request/response
interface vx_tex_csr_file_if
  import vx_tex_pkg::*;
#(
  parameter int NUM_STAGES = 2
);
  localparam int SW = tex_stage_bits(NUM_STAGES);

  logic                     write_enable;
  logic [CSR_ADDR_BITS-1:0] write_addr;
  logic [31:0]              write_data;
  logic [UUID_BITS-1:0]     write_uuid;

  logic                     req_valid;
  logic [SW-1:0]            req_stage;
  logic                     req_ready;

  logic                     rsp_valid;
  logic                     rsp_ready;
  tex_state_t               rsp_state;

  logic [UUID_BITS-1:0]     last_uuid;

  modport master (
    output write_enable, write_addr, write_data, write_uuid,
    output req_valid, req_stage, rsp_ready,
    input  req_ready, rsp_valid, rsp_state, last_uuid
  );

  modport slave (
    input  write_enable, write_addr, write_data, write_uuid,
    input  req_valid, req_stage, rsp_ready,
    output req_ready, rsp_valid, rsp_state, last_uuid
  );

endinterface

// File: rtl/vx_tex_csr_stage.sv
// rtl/vx_tex_csr_stage.sv - one texture stage bank with its field write decode (MIPOFF under TEX_MIPMAP_EN)
module vx_tex_csr_stage
  import vx_tex_pkg::*;
#(
  parameter int NUM_LODS = TEX_MAX_LODS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [CSR_ADDR_BITS-1:0] wr_off_i,
  input  logic [31:0]              wr_data_i,
  output tex_state_t               state_o
);

  tex_state_t state_q, state_d;

  // Field decode: each field keeps only the low bits of the write data.
  always_comb begin
    state_d = state_q;
    if (wr_en_i) begin
      case (wr_off_i)
        OFF_ADDR:   state_d.addr   = wr_data_i;
        OFF_LOGW:   state_d.logw   = wr_data_i[TEX_LOGW_BITS-1:0];
        OFF_LOGH:   state_d.logh   = wr_data_i[TEX_LOGH_BITS-1:0];
        OFF_FORMAT: state_d.format = wr_data_i[TEX_FORMAT_BITS-1:0];
        OFF_WRAPU:  state_d.wrapu  = wr_data_i[TEX_WRAP_BITS-1:0];
        OFF_WRAPV:  state_d.wrapv  = wr_data_i[TEX_WRAP_BITS-1:0];
        OFF_FILTER: state_d.filter = wr_data_i[0];
        default:    ;
      endcase
    end
`ifdef TEX_MIPMAP_EN
    for (int i = 0; i < NUM_LODS; i++) begin
      if (wr_en_i && (wr_off_i == CSR_ADDR_BITS'(int'(OFF_MIPOFF) + i)))
        state_d.mipoff[i] = wr_data_i[TEX_MIPOFF_BITS-1:0];
    end
`else
    // No mip offset storage: these bits stay constant zero.
    for (int i = 0; i < NUM_LODS; i++) state_d.mipoff[i] = '0;
`endif
  end

  // Bank register, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/vx_tex_csr_file.sv
// rtl/vx_tex_csr_file.sv - banked texture CSR file with one-cycle state lookup (MIPOFF under TEX_MIPMAP_EN)
module vx_tex_csr_file
  import vx_tex_pkg::*;
#(
  parameter int                       NUM_STAGES = 2,
  parameter int                       NUM_LODS   = TEX_MAX_LODS,
  parameter logic [CSR_ADDR_BITS-1:0] CSR_BASE   = 12'h7C0
) (
  input  logic            clk,
  input  logic            reset,
  vx_tex_csr_file_if.slave bus
);

  localparam int SW      = tex_stage_bits(NUM_STAGES);
  // The map ends after FILTER unless mip offsets are built in.
  localparam int MAP_LEN = 1 + TEX_NUM_FIELDS + (TEX_MIPMAP ? NUM_LODS : 0);

  logic [CSR_ADDR_BITS-1:0] wr_off;
  logic                     wr_in_map;
  logic                     stage_wr;
  logic                     field_wr;

  logic [SW-1:0]            stage_q, stage_d;
  logic [UUID_BITS-1:0]     last_uuid_q, last_uuid_d;
  logic                     rsp_valid_q, rsp_valid_d;
  tex_state_t               rsp_state_q, rsp_state_d;

  logic                     req_ready;
  logic                     req_accept;
  logic                     req_stage_ok;

  tex_state_t               bank_state [NUM_STAGES];

  // Addresses below the base wrap to large offsets and fall out of the map.
  assign wr_off    = bus.write_addr - CSR_BASE;
  assign wr_in_map = bus.write_enable && (wr_off < CSR_ADDR_BITS'(MAP_LEN));
  assign stage_wr  = wr_in_map && (wr_off == OFF_STAGE);
  assign field_wr  = wr_in_map && (wr_off != OFF_STAGE);

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    vx_tex_csr_stage #(
      .NUM_LODS (NUM_LODS)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (field_wr && (stage_q == SW'(g))),
      .wr_off_i  (wr_off),
      .wr_data_i (bus.write_data),
      .state_o   (bank_state[g])
    );
  end

  assign req_ready    = !rsp_valid_q || bus.rsp_ready;
  assign req_accept   = bus.req_valid && req_ready;
  assign req_stage_ok = {1'b0, bus.req_stage} < (SW + 1)'(NUM_STAGES);

  // Next state for stage select, debug uuid and the response slot.
  always_comb begin
    stage_d     = stage_q;
    last_uuid_d = last_uuid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_state_d = rsp_state_q;

    if (stage_wr && (bus.write_data < 32'(NUM_STAGES)))
      stage_d = bus.write_data[SW-1:0];
    if (wr_in_map)
      last_uuid_d = bus.write_uuid;

    // Banks are sampled before this edge's write lands, giving the pre-write value.
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      rsp_state_d = req_stage_ok ? bank_state[bus.req_stage] : '0;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q     <= '0;
      last_uuid_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_state_q <= '0;
    end else begin
      stage_q     <= stage_d;
      last_uuid_q <= last_uuid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_state_q <= rsp_state_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_state = rsp_state_q;
  assign bus.last_uuid = last_uuid_q;

endmodule

// File: tb/tb_vx_tex_csr_file.sv
// tb/tb_vx_tex_csr_file.sv - scoreboard bench for vx_tex_csr_file (either TEX_MIPMAP_EN build)
module tb_vx_tex_csr_file;
  import vx_tex_pkg::*;

  localparam int               NS   = 2;
  localparam int               NL   = TEX_MAX_LODS;
  localparam logic [11:0]      BASE = 12'h7C0;
`ifdef TEX_MIPMAP_EN
  localparam bit               MIP  = 1'b1;
`else
  localparam bit               MIP  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_tex_csr_file_if #(.NUM_STAGES(NS)) bus ();

  vx_tex_csr_file #(
    .NUM_STAGES (NS),
    .NUM_LODS   (NL),
    .CSR_BASE   (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  tex_state_t           sb [$];
  tex_state_t           m_bank [NS];
  int                   m_stage;
  logic [UUID_BITS-1:0] m_uuid;
  tex_state_t           snap;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) m_bank[i] = '0;
    m_stage = 0;
    m_uuid  = '0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d,
                                      input logic [UUID_BITS-1:0] u);
    logic [11:0] o;
    o = a - BASE;
    if (o == 12'd0) begin
      m_uuid = u;
      if (d < 32'(NS)) m_stage = int'(d);
    end else if (o <= 12'd7) begin
      m_uuid = u;
      case (o)
        12'd1: m_bank[m_stage].addr   = d;
        12'd2: m_bank[m_stage].logw   = d[3:0];
        12'd3: m_bank[m_stage].logh   = d[3:0];
        12'd4: m_bank[m_stage].format = d[2:0];
        12'd5: m_bank[m_stage].wrapu  = d[1:0];
        12'd6: m_bank[m_stage].wrapv  = d[1:0];
        default: m_bank[m_stage].filter = d[0];
      endcase
    end else if (MIP && (int'(o) < 8 + NL)) begin
      m_uuid = u;
      m_bank[m_stage].mipoff[int'(o) - 8] = d[19:0];
    end
  endfunction

  // Compare each completed response handshake against the oldest expectation.
  always @(negedge clk) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 512'(bus.rsp_valid), 512'(0));
      else begin
        tex_state_t e;
        e = sb.pop_front();
        chk("rsp_state", 512'(bus.rsp_state), 512'(e));
      end
    end
  end

  // One clock: record accepted request (pre-write snapshot), then apply write to model.
  task automatic tick();
    @(negedge clk);
    if (bus.req_valid && bus.req_ready) begin
      tex_state_t e;
      e = (int'(bus.req_stage) < NS) ? m_bank[int'(bus.req_stage)] : '0;
      sb.push_back(e);
      snap = e;
    end
    if (bus.write_enable) model_write(bus.write_addr, bus.write_data, bus.write_uuid);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input int off, input logic [31:0] d,
                       input logic [UUID_BITS-1:0] u, input bit rv, input int rs, input bit rr);
    bus.write_enable = we;
    bus.write_addr   = 12'(int'(BASE) + off);
    bus.write_data   = d;
    bus.write_uuid   = u;
    bus.req_valid    = rv;
    bus.req_stage    = 1'(rs);
    bus.rsp_ready    = rr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.write_uuid   = '0;
    bus.req_valid    = 1'b0;
    bus.req_stage    = '0;
    bus.rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 512'(bus.rsp_valid), 512'(0));
    chk("reset_req_ready", 512'(bus.req_ready), 512'(1));
    chk("reset_last_uuid", 512'(bus.last_uuid), 512'(0));
    chk("reset_rsp_state", 512'(bus.rsp_state), 512'(0));
    reset = 1'b1;
    idle(1);

    // Lookup right after reset: all-zero state, one cycle later.
    drive(1'b0, 0, '0, '0, 1'b1, 0, 1'b1);
    chk("first_rsp_valid", 512'(bus.rsp_valid), 512'(1));
    idle(1);
    chk("first_last_uuid", 512'(bus.last_uuid), 512'(0));

    // Program stage 1, read both stages back to back.
    drive(1'b1, 0, 32'd1, 44'd1, 1'b0, 0, 1'b1);
    drive(1'b1, 1, 32'h8000_1000, 44'd2, 1'b0, 0, 1'b1);
    drive(1'b1, 2, 32'h1F, 44'd3, 1'b0, 0, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b1, 0, 1'b1);
    idle(1);
    chk("uuid_after_logw", 512'(bus.last_uuid), 512'(3));

    // Same-cycle write and request: pre-write value, then the new one.
    drive(1'b1, 0, 32'd0, 44'd4, 1'b0, 0, 1'b1);
    drive(1'b1, 4, 32'd5, 44'd5, 1'b1, 0, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b1, 0, 1'b1);
    idle(1);

    // Stall the response while its bank is rewritten.
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b0);
    drive(1'b1, 0, 32'd1, 44'd10, 1'b1, 0, 1'b0);
    chk("stall0_state", 512'(bus.rsp_state), 512'(snap));
    chk("stall0_req_ready", 512'(bus.req_ready), 512'(0));
    chk("stall0_rsp_valid", 512'(bus.rsp_valid), 512'(1));
    drive(1'b1, 1, 32'hDEAD_BEEF, 44'd11, 1'b1, 0, 1'b0);
    chk("stall1_state", 512'(bus.rsp_state), 512'(snap));
    chk("stall1_req_ready", 512'(bus.req_ready), 512'(0));
    drive(1'b1, 3, 32'd7, 44'd12, 1'b1, 0, 1'b0);
    chk("stall2_state", 512'(bus.rsp_state), 512'(snap));
    chk("stall2_req_ready", 512'(bus.req_ready), 512'(0));
    drive(1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
    chk("stall_release_valid", 512'(bus.rsp_valid), 512'(0));
    chk("stall_queue_empty", 512'(sb.size()), 512'(0));

    // Out-of-range STAGE value is dropped but still tags last_uuid.
    drive(1'b1, 0, 32'd7, 44'h77, 1'b0, 0, 1'b1);
    chk("stage7_uuid", 512'(bus.last_uuid), 512'(44'h77));
    drive(1'b1, 7, 32'd1, 44'h88, 1'b0, 0, 1'b1);
    chk("filter_uuid", 512'(bus.last_uuid), 512'(44'h88));
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b1);
    idle(1);

    // Mip offset write: lands only when mipmaps are built in.
    drive(1'b1, 8 + 3, 32'h0001_2345, 44'h99, 1'b0, 0, 1'b1);
    chk("mipoff_uuid", 512'(bus.last_uuid), MIP ? 512'(44'h99) : 512'(44'h88));
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b1);
    idle(1);

    // Out-of-map addresses leave everything alone.
    drive(1'b1, 8 + NL, 32'h1234, 44'hAA, 1'b0, 0, 1'b1);
    drive(1'b1, -1, 32'h1234, 44'hAB, 1'b0, 0, 1'b1);
    drive(1'b1, 64, 32'h1234, 44'hAC, 1'b0, 0, 1'b1);
    chk("oom_uuid", 512'(bus.last_uuid), MIP ? 512'(44'h99) : 512'(44'h88));

    // Upper data bits are discarded.
    drive(1'b1, 5, 32'hFFFF_FFFE, 44'hB0, 1'b0, 0, 1'b1);
    drive(1'b1, 3, 32'hFFFF_FFF3, 44'hB1, 1'b0, 0, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b1);
    idle(1);

    // Back-to-back lookups with ready held high.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, '0, '0, 1'b1, i % 2, 1'b1);
      chk("b2b_rsp_valid", 512'(bus.rsp_valid), 512'(1));
    end
    idle(1);

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      int          off;
      logic [31:0] d;
      off = int'($urandom_range(0, 8 + NL + 1));
      d   = (off == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      drive(1'($urandom_range(0, 1)), off, d, 44'(256 + i),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end
    idle(3);
    chk("rand_drain", 512'(sb.size()), 512'(0));
    chk("rand_last_uuid", 512'(bus.last_uuid), 512'(m_uuid));

    // Reset mid-transfer drops the pending response and clears all state.
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    reset = 1'b0;
    #2;
    chk("midrst_rsp_valid", 512'(bus.rsp_valid), 512'(0));
    chk("midrst_last_uuid", 512'(bus.last_uuid), 512'(0));
    chk("midrst_rsp_state", 512'(bus.rsp_state), 512'(0));
    sb.delete();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    drive(1'b0, 0, '0, '0, 1'b1, 1, 1'b1);
    drive(1'b0, 0, '0, '0, 1'b1, 0, 1'b1);
    idle(2);
    chk("final_drain", 512'(sb.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
